// File: rtl/dmem_pkg.sv
// Shared types for the data-memory request/response path between MEM stage and responder.
// No logic; types, constants and a helper only.
// Not applicable (no flow control lives here).
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dmem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } dmem_resp_t;

   localparam int DMEM_WORD_BYTES = 4;
   localparam int DMEM_CNT_W      = 4;

   // Word accesses must sit on a 4-byte boundary.
   function automatic logic dmem_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the data-memory responder (slave).
// Pure wiring, zero latency.
// req_* is valid/ready; resp_* is valid/ready; busy mirrors an outstanding request.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic                       req_valid;
   logic                       req_ready;
   logic                       req_write;
   logic [31:0]                req_addr;
   logic [31:0]                req_wdata;
   logic [DMEM_WORD_BYTES-1:0] req_be;
   logic                       resp_valid;
   logic                       resp_ready;
   logic [31:0]                resp_rdata;
   logic                       resp_err;
   logic                       busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );

endinterface

// File: rtl/dmem_word_ram.sv
// Single-port word RAM with per-byte write enables; no reset, contents survive responder reset.
// Read data registered on the access edge (one edge after address is presented).
// No flow control; the caller gates rd_en / wr_be.
module dmem_word_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clock,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic                           rd_en,
   input  logic [DMEM_WORD_BYTES-1:0]     wr_be,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane writes and registered read share the single access port.
   always_ff @(posedge clock) begin
      if (rd_en) begin
         rdata <= mem[addr];
      end
      for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
         if (wr_be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a byte-enable word RAM, with error check.
// Response valid LATENCY cycles after acceptance (1..15).
// Response held until resp_ready; no new request accepted until the cycle after the response handshake.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic             clock,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);
   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 1..15");
   end
   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
   end

   dmem_req_t                 req;
   dmem_resp_t                resp;
   dmem_state_t               state_q, state_d;
   logic [DMEM_CNT_W-1:0]     cnt_q, cnt_d;
   logic                      ready_en_q;
   logic                      load_ok_q;
   logic                      err_q;
   logic                      accept;
   logic                      addr_err;
   logic [AW-1:0]             ram_addr;
   logic                      ram_rd_en;
   logic [DMEM_WORD_BYTES-1:0] ram_wr_be;
   logic [31:0]               ram_rdata;

   assign req.write = bus.req_write;
   assign req.addr  = bus.req_addr;
   assign req.wdata = bus.req_wdata;
   assign req.be    = bus.req_be;

   assign accept   = bus.req_valid & bus.req_ready;
   // The range test uses the full word index so high address bits cannot alias into the RAM.
   assign addr_err = dmem_misaligned(req.addr) | ({2'b00, req.addr[31:2]} >= DEPTH_LIMIT);

   assign ram_addr  = req.addr[2 +: AW];
   assign ram_rd_en = accept & ~req.write & ~addr_err;
   assign ram_wr_be = (accept & req.write & ~addr_err) ? req.be : '0;

   dmem_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clock (clock),
      .addr  (ram_addr),
      .rd_en (ram_rd_en),
      .wr_be (ram_wr_be),
      .wdata (req.wdata),
      .rdata (ram_rdata)
   );

   // The RAM's read register holds the load word; load_ok_q gates it so stores, errors and idle read as zero.
   assign resp.rdata = load_ok_q ? ram_rdata : 32'h0;
   assign resp.err   = err_q;

   assign bus.req_ready  = ready_en_q & (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.busy       = (state_q != IDLE);
   assign bus.resp_rdata = resp.rdata;
   assign bus.resp_err   = resp.err;

   // State and latency counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: accept in IDLE, count down in BUSY, wait for the consumer in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY > 1) begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DMEM_CNT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Keep req_ready low while reset is held and until the first edge after release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end

   // Capture the outcome at acceptance; clear it when the response is consumed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         load_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (accept) begin
         load_ok_q <= ~req.write & ~addr_err;
         err_q     <= addr_err;
      end else if ((state_q == RESP) && bus.resp_ready) begin
         load_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the data-memory interface driven by the pipeline MEM stage.
- Accepts one load or store request at a time and applies it to a word-organised RAM with byte-enable writes.
- Returns a response after a programmable latency; the MEM stage stalls while waiting.
- Replaces the zero-latency dmemData path with a real valid/ready handshake.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 2: cycles from request acceptance to first resp_valid; legal range 1–15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; ignored on loads.
- resp_valid  out  1  response available.
- resp_ready  in  1  MEM stage consumes the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.
- busy  out  1  request accepted but response not yet consumed; drives pipeline stall.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, counter = 0.
  - Outputs: req_ready = 0 while reset is asserted, 1 from the first cycle after deassertion; resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0.
  - RAM contents are not cleared.
  - Reset during BUSY or RESP drops the pending response; a store already committed stays committed.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1, busy = 0.
  - Acceptance = req_valid & req_ready at a rising edge (edge N).
  - At edge N: error check, memory access, result captured into resp_rdata/resp_err registers.
  - Next state: BUSY if LATENCY > 1, with counter loaded with LATENCY-1; RESP if LATENCY = 1.
- BUSY:
  - req_ready = 0, busy = 1.
  - Counter decrements each cycle; on reaching 1, the next state is RESP.
  - Result: resp_valid first asserts in the cycle after edge N+LATENCY-1, i.e. visible LATENCY cycles after acceptance.
- RESP:
  - resp_valid = 1, busy = 1, req_ready = 0.
  - resp_rdata and resp_err are held stable until resp_ready = 1.
  - At the edge where resp_valid & resp_ready: go to IDLE, clear resp_valid, resp_rdata and resp_err.
  - A new request can be accepted one cycle later; there is no back-to-back accept in the same cycle as the response handshake.
- Error check at acceptance:
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: word index req_addr[31:2] ≥ DEPTH_WORDS.
  - On error: resp_err = 1, resp_rdata = 0, no RAM write; the request still completes through BUSY/RESP with normal latency.
- Load: resp_rdata = RAM[req_addr[2+:log2(DEPTH_WORDS)]], read at edge N, so there is no read-after-write hazard inside the block.
- Store:
  - At edge N, for each i with req_be[i] = 1, byte i of the word is written from req_wdata[8i+7:8i]; other bytes are unchanged.
  - req_be = 0 is a legal no-op store.
  - resp_rdata = 0 and resp_err = 0 (unless an error was flagged).
- Request inputs are ignored when req_ready = 0. The requester must hold a request until it is accepted.
- Counter width is 4 bits. LATENCY outside 1–15 is a elaboration-time error (assertion).

Decomposition:
- Shared package dmem_pkg:
  - Enum dmem_state_t {IDLE, BUSY, RESP}.
  - Struct dmem_req_t {write, addr, wdata, be}.
  - Struct dmem_resp_t {rdata, err}.
  - Constant DMEM_WORD_BYTES = 4.
- The MEM stage and top level reuse these structs to replace the dmemData wiring.
- Sub-module dmem_word_ram: synchronous single-port RAM with 4-bit byte-enable write, combinational-address read registered on the access edge, no reset, DEPTH_WORDS parameter.
- dmem_responder contains the FSM, latency counter, error check and response registers.

Test Plan:
- Reset then idle: release reset → req_ready = 1, resp_valid = 0, busy = 0 the next cycle.
- Store then load, LATENCY = 2:
  - SW addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at edge N → resp_valid first high in the cycle after edge N+1, resp_err = 0.
  - LW 0x10 → resp_rdata = 0xDEADBEEF after 2 cycles.
- Byte enables: after the word 0xDEADBEEF, SW addr 0x10, wdata 0x000000AA, be 4'b0001 → LW 0x10 returns 0xDEADBEAA.
- Errors:
  - LW 0x13 → resp_err = 1, resp_rdata = 0.
  - SW to address 4*DEPTH_WORDS (0x1000 at default) → resp_err = 1 and no RAM word changes (check word 0 unchanged).
- Back-pressure: hold resp_ready = 0 for 5 cycles in RESP → resp_valid, resp_rdata stable and req_ready = 0 throughout; req_valid pulses are not accepted.
- Mid-operation reset: assert reset during BUSY after SW 0x20 = 0x12345678 → outputs clear immediately, state IDLE; after release, LW 0x20 returns 0x12345678. Also run with LATENCY = 1 (resp_valid high in the cycle after acceptance).
